// File: rtl/ddr2_cmd_arbiter_pkg.sv
// Shared definitions for the DDR2 command arbiter: widths, command
// encodings, one-hot state encodings and source indices.
package ddr2_cmd_arbiter_pkg;

  localparam int DDR2_BA_BITS   = 3;
  localparam int DDR2_ADDR_BITS = 13;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_DESEL = 4'b1111;

  // Request/grant vector layout, shared by the picker and the top
  localparam int NUM_SRC  = 3;
  localparam int SRC_AREF = 0;
  localparam int SRC_WR   = 1;
  localparam int SRC_RD   = 2;

  typedef enum logic [4:0] {
    ST_INIT  = 5'b00001,
    ST_IDLE  = 5'b00010,
    ST_AREF  = 5'b00100,
    ST_WRITE = 5'b01000,
    ST_READ  = 5'b10000
  } arb_state_e;

  // Round-robin memory between the write and read sources
  typedef enum logic {
    LS_WRITE = 1'b0,
    LS_READ  = 1'b1
  } last_served_e;

endpackage

// File: rtl/ddr2_arb_pick.sv
// Combinational grant picker: refresh has absolute priority, write/read
// contention is broken by whichever of the two was not served last.
module ddr2_arb_pick
  import ddr2_cmd_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  last_served_e       last_served,
  output logic [NUM_SRC-1:0] grant
);

  // One-hot grant; all-zero when nothing is requesting
  always_comb begin
    grant = '0;
    if (req[SRC_AREF]) begin
      grant[SRC_AREF] = 1'b1;
    end else if (req[SRC_WR] && req[SRC_RD]) begin
      if (last_served == LS_READ) grant[SRC_WR] = 1'b1;
      else                        grant[SRC_RD] = 1'b1;
    end else if (req[SRC_WR]) begin
      grant[SRC_WR] = 1'b1;
    end else if (req[SRC_RD]) begin
      grant[SRC_RD] = 1'b1;
    end
  end

endmodule

// File: rtl/ddr2_cmd_arbiter.sv
// DDR2 command arbiter: selects between the init sequencer and the
// refresh/write/read engines and drives a registered command bus.
module ddr2_cmd_arbiter
  import ddr2_cmd_arbiter_pkg::*;
#(
  parameter int BA_BITS   = DDR2_BA_BITS,
  parameter int ADDR_BITS = DDR2_ADDR_BITS
) (
  input  logic                 ck,
  input  logic                 rst_n,
  // init sequencer
  input  logic                 init_cke,
  input  logic [3:0]           init_cmd,
  input  logic [BA_BITS-1:0]   init_ba,
  input  logic [ADDR_BITS-1:0] init_addr,
  input  logic                 init_end,
  // auto-refresh engine
  input  logic                 aref_req,
  output logic                 aref_en,
  input  logic [3:0]           aref_cmd,
  input  logic [ADDR_BITS-1:0] aref_addr,
  input  logic                 aref_end,
  // write engine
  input  logic                 wr_req,
  output logic                 wr_en,
  input  logic [3:0]           wr_cmd,
  input  logic [BA_BITS-1:0]   wr_ba,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic                 wr_end,
  // read engine
  input  logic                 rd_req,
  output logic                 rd_en,
  input  logic [3:0]           rd_cmd,
  input  logic [BA_BITS-1:0]   rd_ba,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic                 rd_end,
  // DRAM side
  output logic                 ddr2_ck,
  output logic                 ddr2_ck_n,
  output logic                 ddr2_cke,
  output logic                 ddr2_cs_n,
  output logic                 ddr2_ras_n,
  output logic                 ddr2_cas_n,
  output logic                 ddr2_we_n,
  output logic [BA_BITS-1:0]   ddr2_ba,
  output logic [ADDR_BITS-1:0] ddr2_addr,
  output logic [4:0]           arb_state
);

  arb_state_e           state_q, state_d;
  last_served_e         last_q, last_d;
  logic [NUM_SRC-1:0]   req, grant;
  logic [NUM_SRC-1:0]   en_q, en_d;
  logic [3:0]           cmd_q, cmd_d;
  logic [BA_BITS-1:0]   ba_q, ba_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;

  assign req[SRC_AREF] = aref_req;
  assign req[SRC_WR]   = wr_req;
  assign req[SRC_RD]   = rd_req;

  ddr2_arb_pick u_pick (
    .req         (req),
    .last_served (last_q),
    .grant       (grant)
  );

  // Next state, grant pulses and round-robin update
  always_comb begin
    state_d = state_q;
    en_d    = '0;
    last_d  = last_q;
    case (state_q)
      ST_INIT: begin
        if (init_end) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // *_end is meaningless here; only requests move the FSM
        if (grant[SRC_AREF]) begin
          state_d        = ST_AREF;
          en_d[SRC_AREF] = 1'b1;
        end else if (grant[SRC_WR]) begin
          state_d      = ST_WRITE;
          en_d[SRC_WR] = 1'b1;
          last_d       = LS_WRITE;
        end else if (grant[SRC_RD]) begin
          state_d      = ST_READ;
          en_d[SRC_RD] = 1'b1;
          last_d       = LS_READ;
        end
      end
      ST_AREF: begin
        if (aref_end) state_d = ST_IDLE;
      end
      ST_WRITE: begin
        // A pending refresh is chained in directly to avoid an idle bubble
        if (wr_end) begin
          if (aref_req) begin
            state_d        = ST_AREF;
            en_d[SRC_AREF] = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        if (rd_end) begin
          if (aref_req) begin
            state_d        = ST_AREF;
            en_d[SRC_AREF] = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Command mux keyed on the state being entered, so the registered
  // command lines up with arb_state on the same cycle
  always_comb begin
    cmd_d  = CMD_NOP;
    ba_d   = '0;
    addr_d = '0;
    case (state_d)
      ST_INIT: begin
        cmd_d  = init_cmd;
        ba_d   = init_ba;
        addr_d = init_addr;
      end
      ST_AREF: begin
        cmd_d  = aref_cmd;
        addr_d = aref_addr;
      end
      ST_WRITE: begin
        cmd_d  = wr_cmd;
        ba_d   = wr_ba;
        addr_d = wr_addr;
      end
      ST_READ: begin
        cmd_d  = rd_cmd;
        ba_d   = rd_ba;
        addr_d = rd_addr;
      end
      default: ;
    endcase
  end

  // State, grant and round-robin registers
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      en_q    <= '0;
      last_q  <= LS_READ;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      last_q  <= last_d;
    end
  end

  // Registered command bus; deselect while in reset
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q  <= CMD_DESEL;
      ba_q   <= '0;
      addr_q <= '0;
    end else begin
      cmd_q  <= cmd_d;
      ba_q   <= ba_d;
      addr_q <= addr_d;
    end
  end

  assign aref_en   = en_q[SRC_AREF];
  assign wr_en     = en_q[SRC_WR];
  assign rd_en     = en_q[SRC_RD];

  assign ddr2_ck   = ck;
  assign ddr2_ck_n = ~ck;
  assign ddr2_cke  = init_cke;

  assign {ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n} = cmd_q;
  assign ddr2_ba   = ba_q;
  assign ddr2_addr = addr_q;
  assign arb_state = state_q;

endmodule

// File: tb/tb_ddr2_cmd_arbiter.sv
// Scoreboard bench for ddr2_cmd_arbiter: each step queues the expected
// observation, clocks once and compares it against the DUT outputs.
module tb_ddr2_cmd_arbiter;
  import ddr2_cmd_arbiter_pkg::*;

  localparam logic [3:0]  INIT_CMD  = 4'b0010;
  localparam logic [2:0]  INIT_BA   = 3'd3;
  localparam logic [12:0] INIT_ADDR = 13'h0400;
  localparam logic [3:0]  AREF_CMD  = 4'b0001;
  localparam logic [12:0] AREF_ADDR = 13'h00AA;
  localparam logic [3:0]  WR_CMD    = 4'b0100;
  localparam logic [2:0]  WR_BA     = 3'd5;
  localparam logic [12:0] WR_ADDR   = 13'h0123;
  localparam logic [3:0]  RD_CMD    = 4'b0101;
  localparam logic [2:0]  RD_BA     = 3'd2;
  localparam logic [12:0] RD_ADDR   = 13'h0456;

  typedef struct packed {
    logic [4:0]  st;
    logic [2:0]  en;   // {rd, wr, aref}
    logic [3:0]  cmd;
    logic [2:0]  ba;
    logic [12:0] addr;
  } obs_t;

  logic        ck, rst_n;
  logic        init_cke, init_end;
  logic [3:0]  init_cmd;
  logic [2:0]  init_ba;
  logic [12:0] init_addr;
  logic        aref_req, aref_en, aref_end;
  logic [3:0]  aref_cmd;
  logic [12:0] aref_addr;
  logic        wr_req, wr_en, wr_end;
  logic [3:0]  wr_cmd;
  logic [2:0]  wr_ba;
  logic [12:0] wr_addr;
  logic        rd_req, rd_en, rd_end;
  logic [3:0]  rd_cmd;
  logic [2:0]  rd_ba;
  logic [12:0] rd_addr;
  logic        ddr2_ck, ddr2_ck_n, ddr2_cke;
  logic        ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n;
  logic [2:0]  ddr2_ba;
  logic [12:0] ddr2_addr;
  logic [4:0]  arb_state;

  int   n_chk, n_pass;
  obs_t exp_q[$];

  ddr2_cmd_arbiter dut (
    .ck(ck), .rst_n(rst_n),
    .init_cke(init_cke), .init_cmd(init_cmd), .init_ba(init_ba),
    .init_addr(init_addr), .init_end(init_end),
    .aref_req(aref_req), .aref_en(aref_en), .aref_cmd(aref_cmd),
    .aref_addr(aref_addr), .aref_end(aref_end),
    .wr_req(wr_req), .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_ba(wr_ba),
    .wr_addr(wr_addr), .wr_end(wr_end),
    .rd_req(rd_req), .rd_en(rd_en), .rd_cmd(rd_cmd), .rd_ba(rd_ba),
    .rd_addr(rd_addr), .rd_end(rd_end),
    .ddr2_ck(ddr2_ck), .ddr2_ck_n(ddr2_ck_n), .ddr2_cke(ddr2_cke),
    .ddr2_cs_n(ddr2_cs_n), .ddr2_ras_n(ddr2_ras_n), .ddr2_cas_n(ddr2_cas_n),
    .ddr2_we_n(ddr2_we_n), .ddr2_ba(ddr2_ba), .ddr2_addr(ddr2_addr),
    .arb_state(arb_state)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic obs_t mk(logic [4:0] st, logic [2:0] en, logic [3:0] cmd,
                              logic [2:0] ba, logic [12:0] addr);
    obs_t o;
    o.st = st; o.en = en; o.cmd = cmd; o.ba = ba; o.addr = addr;
    return o;
  endfunction

  function automatic obs_t o_rst();               return mk(5'b00001, 3'b000, 4'b1111, 3'd0, 13'd0); endfunction
  function automatic obs_t o_init();              return mk(5'b00001, 3'b000, INIT_CMD, INIT_BA, INIT_ADDR); endfunction
  function automatic obs_t o_idle();              return mk(5'b00010, 3'b000, 4'b0111, 3'd0, 13'd0); endfunction
  function automatic obs_t o_aref(logic p);       return mk(5'b00100, {2'b00, p}, AREF_CMD, 3'd0, AREF_ADDR); endfunction
  function automatic obs_t o_wr(logic p);         return mk(5'b01000, {1'b0, p, 1'b0}, WR_CMD, WR_BA, WR_ADDR); endfunction
  function automatic obs_t o_rd(logic p);         return mk(5'b10000, {p, 2'b00}, RD_CMD, RD_BA, RD_ADDR); endfunction

  task automatic check_now(input string tag, input obs_t e);
    chk({tag, ".state"}, 32'(arb_state), 32'(e.st));
    chk({tag, ".en"},    32'({rd_en, wr_en, aref_en}), 32'(e.en));
    chk({tag, ".cmd"},   32'({ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n}), 32'(e.cmd));
    chk({tag, ".ba"},    32'(ddr2_ba), 32'(e.ba));
    chk({tag, ".addr"},  32'(ddr2_addr), 32'(e.addr));
  endtask

  // Queue the expectation for the coming edge, clock, then retire it
  task automatic step(input string tag, input obs_t e);
    obs_t got_exp;
    exp_q.push_back(e);
    @(posedge ck); #1;
    got_exp = exp_q.pop_front();
    check_now(tag, got_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    init_cke = 1'b0; init_cmd = INIT_CMD; init_ba = INIT_BA; init_addr = INIT_ADDR; init_end = 1'b0;
    aref_req = 1'b0; aref_cmd = AREF_CMD; aref_addr = AREF_ADDR; aref_end = 1'b0;
    wr_req = 1'b0; wr_cmd = WR_CMD; wr_ba = WR_BA; wr_addr = WR_ADDR; wr_end = 1'b0;
    rd_req = 1'b0; rd_cmd = RD_CMD; rd_ba = RD_BA; rd_addr = RD_ADDR; rd_end = 1'b0;

    // Reset state and clock/cke pass-throughs
    repeat (2) @(posedge ck);
    @(negedge ck);
    check_now("reset", o_rst());
    chk("ck_pass", 32'(ddr2_ck), 32'(ck));
    chk("ck_n_pass", 32'(ddr2_ck_n), 32'(!ck));
    chk("cke_lo", 32'(ddr2_cke), 32'd0);
    init_cke = 1'b1;
    #1 chk("cke_hi", 32'(ddr2_cke), 32'd1);

    // Release: init command one edge later, then init_end to IDLE
    rst_n = 1'b1;
    step("init_first", o_init());
    step("init_hold", o_init());
    init_end = 1'b1;
    step("init_to_idle", o_idle());
    init_end = 1'b0;
    step("idle_nop", o_idle());

    // All three request: refresh first, then write, then read
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    step("all_aref_grant", o_aref(1'b1));
    aref_req = 1'b0;
    step("aref_pulse_end", o_aref(1'b0));
    aref_end = 1'b1;
    step("aref_done", o_idle());
    aref_end = 1'b0;
    step("all_wr_grant", o_wr(1'b1));
    wr_req = 1'b0; wr_end = 1'b1;
    step("wr_done", o_idle());
    wr_end = 1'b0;
    step("all_rd_grant", o_rd(1'b1));
    rd_req = 1'b0; rd_end = 1'b1;
    step("rd_done", o_idle());
    rd_end = 1'b0;

    // Contention held high: W,R,W,R with single-cycle enables
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step($sformatf("rr%0d_w", i), o_wr(1'b1));
      step($sformatf("rr%0d_w_pulse", i), o_wr(1'b0));
      wr_end = 1'b1;
      step($sformatf("rr%0d_w_end", i), o_idle());
      wr_end = 1'b0;
      step($sformatf("rr%0d_r", i), o_rd(1'b1));
      step($sformatf("rr%0d_r_pulse", i), o_rd(1'b0));
      rd_end = 1'b1;
      step($sformatf("rr%0d_r_end", i), o_idle());
      rd_end = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0;

    // Refresh chained directly after write, then after read
    wr_req = 1'b1;
    step("chain_wr", o_wr(1'b1));
    wr_req = 1'b0; aref_req = 1'b1;
    step("chain_wr_hold", o_wr(1'b0));
    wr_end = 1'b1;
    step("chain_wr_aref", o_aref(1'b1));
    wr_end = 1'b0; aref_req = 1'b0;
    step("chain_aref_hold", o_aref(1'b0));
    aref_end = 1'b1;
    step("chain_aref_end", o_idle());
    aref_end = 1'b0;
    rd_req = 1'b1;
    step("chain_rd", o_rd(1'b1));
    rd_req = 1'b0; aref_req = 1'b1; rd_end = 1'b1;
    step("chain_rd_aref", o_aref(1'b1));
    rd_end = 1'b0; aref_req = 1'b0; aref_end = 1'b1;
    step("chain_rd_aref_end", o_idle());
    aref_end = 1'b0;

    // Request and end together in IDLE resolve as a grant
    wr_req = 1'b1; wr_end = 1'b1;
    step("req_end_idle", o_wr(1'b1));
    wr_req = 1'b0; wr_end = 1'b0;
    step("req_end_hold", o_wr(1'b0));
    wr_end = 1'b1;
    step("req_end_done", o_idle());
    wr_end = 1'b0;

    // Stray ends in IDLE are ignored
    rd_end = 1'b1; aref_end = 1'b1;
    step("idle_stray_end", o_idle());
    rd_end = 1'b0; aref_end = 1'b0;

    // Illegal encoding recovers to INIT on the next edge
    @(negedge ck);
    force dut.state_q = arb_state_e'(5'b00000);
    #1 release dut.state_q;
    chk("illegal_seen", 32'(arb_state), 32'd0);
    step("illegal_recover", o_init());
    init_end = 1'b1;
    step("reinit_idle", o_idle());
    init_end = 1'b0;

    // Reset mid-read aborts asynchronously
    rd_req = 1'b1;
    step("pre_rst_rd", o_rd(1'b1));
    rd_req = 1'b0;
    step("pre_rst_rd_hold", o_rd(1'b0));
    #2 rst_n = 1'b0;
    rd_end = 1'b1;
    #1 check_now("rst_async", o_rst());
    @(posedge ck); #1;
    check_now("rst_held", o_rst());
    @(negedge ck);
    rst_n = 1'b1; rd_end = 1'b0;
    step("rst_release_init", o_init());
    init_end = 1'b1;
    step("final_idle", o_idle());
    init_end = 1'b0;

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
